align_word_packer: RTL and testbench

ALIGN_WORD_PACKER -- requirements
Module: align_word_packer

---
 rtl/align_word_packer.sv | 127 ++++++++++++
 tb/tb_align_word_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/align_word_packer.sv
// align_word_packer: packs pairs of N-bit words into 2N-bit words.
// A lone final word of a packet leaves as a half word with the upper half zero.
// Packed words queue in a 2-entry output FIFO; o_stall is driven from registers only.
//
// state    | meaning
// LO_EMPTY | no word held in the low register
// LO_HELD  | one word held in the low register (with its last flag)
module align_word_packer #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i_data,
  input  logic           i_last,
  input  logic           i_valid,
  output logic           o_stall,
  output logic [2*N-1:0] o_data,
  output logic           o_last,
  output logic           o_half,
  output logic           o_valid,
  input  logic           i_stall
);

  typedef enum logic {
    LO_EMPTY = 1'b0,
    LO_HELD  = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   lo_data;
  logic           lo_last;

  logic [2*N-1:0] fifo_data [2];
  logic           fifo_last [2];
  logic           fifo_half [2];
  logic [1:0]     head;
  logic [1:0]     tail;

  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           enq;
  logic [2*N-1:0] enq_data;
  logic           enq_last;
  logic           enq_half;

  // Pointer compare: the extra wrap bit distinguishes full from empty.
  assign fifo_empty = (head == tail);
  assign fifo_full  = (head[0] == tail[0]) && (head[1] != tail[1]);

  // A full FIFO refuses every push, even one that would only fill the low register,
  // so o_stall never has to look at i_last or i_valid.
  assign push = i_valid && !fifo_full;
  assign pop  = !fifo_empty && !i_stall;
  assign enq  = push && ((state == LO_HELD) || i_last);

  // Packed word formed from the held low word (if any) and the incoming word.
  always_comb begin
    enq_data = '0;
    enq_last = 1'b0;
    enq_half = 1'b0;
    if (state == LO_HELD) begin
      enq_data = {i_data, lo_data};
      enq_last = i_last || lo_last;
      enq_half = 1'b0;
    end else begin
      enq_data = {{N{1'b0}}, i_data};
      enq_last = 1'b1;
      enq_half = 1'b1;
    end
  end

  // Packer FSM: holds the first word of a pair until its partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LO_EMPTY;
      lo_data <= '0;
      lo_last <= 1'b0;
    end else if (push) begin
      case (state)
        LO_EMPTY: begin
          if (!i_last) begin
            lo_data <= i_data;
            lo_last <= i_last;
            state   <= LO_HELD;
          end
        end
        LO_HELD: begin
          lo_last <= 1'b0;
          state   <= LO_EMPTY;
        end
        default: state <= LO_EMPTY;
      endcase
    end
  end

  // Output FIFO storage and pointers; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        fifo_data[k] <= '0;
        fifo_last[k] <= 1'b0;
        fifo_half[k] <= 1'b0;
      end
      head <= 2'd0;
      tail <= 2'd0;
    end else begin
      if (enq) begin
        fifo_data[tail[0]] <= enq_data;
        fifo_last[tail[0]] <= enq_last;
        fifo_half[tail[0]] <= enq_half;
        tail               <= tail + 2'd1;
      end
      if (pop) begin
        head <= head + 2'd1;
      end
    end
  end

  assign o_data  = fifo_data[head[0]];
  assign o_last  = fifo_last[head[0]];
  assign o_half  = fifo_half[head[0]];
  assign o_valid = !fifo_empty;
  assign o_stall = fifo_full;

endmodule

// File: tb/tb_align_word_packer.sv
// Self-checking bench for align_word_packer: directed steps plus a random stream,
// with a scoreboard queue of expected packed words.
module tb_align_word_packer;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   i_data = '0;
  logic           i_last = 1'b0;
  logic           i_valid = 1'b0;
  logic           i_stall = 1'b0;
  logic           o_stall;
  logic [2*N-1:0] o_data;
  logic           o_last;
  logic           o_half;
  logic           o_valid;

  typedef struct packed {
    logic [2*N-1:0] d;
    logic           l;
    logic           h;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic         m_held = 1'b0;
  logic [N-1:0] m_lo = '0;
  int           occ;
  bit           m_push;
  bit           m_pop;

  int vectors = 0;
  int miscompares = 0;

  align_word_packer #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_valid (i_valid),
    .o_stall (o_stall),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_half  (o_half),
    .o_valid (o_valid),
    .i_stall (i_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: at each falling edge, decide what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_held = 1'b0;
    end else begin
      occ    = sb.size();
      m_push = i_valid && (occ < 2);
      m_pop  = (occ != 0) && !i_stall;
      chk("o_valid", o_valid, occ != 0);
      chk("o_stall", o_stall, occ == 2);
      if (m_pop) begin
        e = sb.pop_front();
        chk("o_data", o_data, e.d);
        chk("o_last", o_last, e.l);
        chk("o_half", o_half, e.h);
      end
      if (m_push) begin
        if (m_held) begin
          sb.push_back('{d: {i_data, m_lo}, l: i_last, h: 1'b0});
          m_held = 1'b0;
        end else if (i_last) begin
          sb.push_back('{d: {{N{1'b0}}, i_data}, l: 1'b1, h: 1'b1});
        end else begin
          m_lo   = i_data;
          m_held = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [N-1:0] d, input logic l, input logic s);
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_last  = l;
    i_stall = s;
  endtask

  task automatic chk_out(input string tag, input logic [2*N-1:0] d, input logic l, input logic h);
    @(negedge clk);
    chk({tag, "_valid"}, o_valid, 1'b1);
    chk({tag, "_data"}, o_data, d);
    chk({tag, "_last"}, o_last, l);
    chk({tag, "_half"}, o_half, h);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_stall = 1'b0;
    #1;
    chk({tag, "_valid"}, o_valid, 1'b0);
    chk({tag, "_stall"}, o_stall, 1'b0);
    chk({tag, "_data"}, o_data, '0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic         last_w;
    logic         accepted;
    logic         s0;
    logic [N-1:0] dw;

    #3;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_stall", o_stall, 1'b0);
    chk("rst_data", o_data, '0);
    chk("rst_last", o_last, 1'b0);
    chk("rst_half", o_half, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Pair of words forming one full packed word
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk_out("pair", 32'h2222_1111, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pair_drained", o_valid, 1'b0);

    // Lone last word leaves as a half word one cycle later
    drive(1'b1, 16'h00AB, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk_out("half", 32'h0000_00AB, 1'b1, 1'b1);

    // Downstream stalled: two packed words fill the FIFO, fifth word waits
    drive(1'b1, 16'h0001, 1'b0, 1'b1);
    drive(1'b1, 16'h0002, 1'b0, 1'b1);
    drive(1'b1, 16'h0003, 1'b0, 1'b1);
    drive(1'b1, 16'h0004, 1'b0, 1'b1);
    drive(1'b1, 16'h0005, 1'b0, 1'b1);
    chk_out("full_head", 32'h0002_0001, 1'b0, 1'b0);
    chk("full_stall", o_stall, 1'b1);
    // Release: pop while full, push refused
    drive(1'b1, 16'h0005, 1'b0, 1'b0);
    chk_out("pop_full", 32'h0002_0001, 1'b0, 1'b0);
    chk("pop_full_stall", o_stall, 1'b1);
    drive(1'b1, 16'h0005, 1'b0, 1'b0);
    chk_out("occ_one", 32'h0004_0003, 1'b0, 1'b0);
    chk("occ_one_stall", o_stall, 1'b0);
    drive(1'b1, 16'h0006, 1'b1, 1'b0);
    @(negedge clk);
    chk("word5_held", o_valid, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk_out("word56", 32'h0006_0005, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset with a full FIFO and a word offered
    drive(1'b1, 16'h0011, 1'b0, 1'b1);
    drive(1'b1, 16'h0012, 1'b0, 1'b1);
    drive(1'b1, 16'h0013, 1'b0, 1'b1);
    drive(1'b1, 16'h0014, 1'b0, 1'b1);
    drive(1'b1, 16'h0015, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_rst_stall", o_stall, 1'b1);
    async_reset("rst_full");

    // Asynchronous reset while a low word is held: that word must be dropped
    drive(1'b1, 16'h0008, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    async_reset("rst_held");
    drive(1'b1, 16'h0007, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk_out("post_rst", 32'h0000_0007, 1'b1, 1'b1);

    // Random stream; o_stall must not react to a same-cycle change of i_stall
    for (int w = 0; w < 1000; w++) begin
      last_w = (w == 999) ? 1'b1 : ($urandom_range(0, 3) == 0);
      dw     = N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
      end
      accepted = 1'b0;
      for (int t = 0; t < 40 && !accepted; t++) begin
        @(posedge clk);
        #1;
        s0      = o_stall;
        i_valid = 1'b1;
        i_data  = dw;
        i_last  = last_w;
        i_stall = 1'($urandom_range(0, 1));
        #1;
        chk("stall_indep", o_stall, s0);
        accepted = !o_stall;
      end
      if (!accepted) begin
        chk("accept_timeout", accepted, 1'b1);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
